// File: rtl/mont_sched_pkg.sv
// -----------------------------------------------------------------------------
// mont_sched_pkg
// Shared definitions for the Montgomery multiplier scheduler:
//   - MONT_SCHED_N : modulus macro, p = 2^255 - 19
//   - MONT_W       : operand / result width (255)
//   - WDOG_DEFAULT : default WAIT-state watchdog limit in cycles
//   - state_t      : scheduler FSM states
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef MONT_SCHED_N
`define MONT_SCHED_N ({255{1'b1}} - 255'd18)
`endif

package mont_sched_pkg;

    localparam int MONT_W       = 255;
    localparam int WDOG_DEFAULT = 300;

    localparam logic [MONT_W-1:0] N_MOD = `MONT_SCHED_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mont_sched_mont.sv
// -----------------------------------------------------------------------------
// mont_sched_mont
// Bit-serial radix-2 Montgomery multiplier: res = A * B * 2^-255 mod N_MOD.
// Operands are loaded on the cycle start_i is sampled; 255 iterations follow,
// and done_o pulses for one cycle together with the fully reduced result.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_i   : synchronous active-high reset
//   start_i : load operands and begin a new product
//   a_i/b_i : 255-bit operands (need not be reduced mod N_MOD)
//   done_o  : one-cycle completion pulse
//   res_o   : product, held until the next completion
// -----------------------------------------------------------------------------
module mont_sched_mont
    import mont_sched_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [MONT_W-1:0] a_i,
    input  logic [MONT_W-1:0] b_i,
    output logic              done_o,
    output logic [MONT_W-1:0] res_o
);

    localparam logic [MONT_W+1:0] N_EXT  = {2'b00, N_MOD};
    localparam logic [MONT_W+1:0] N2_EXT = {1'b0, N_MOD, 1'b0};

    logic [MONT_W-1:0] a_q;
    logic [MONT_W-1:0] b_q;
    logic [MONT_W+1:0] acc_q;
    logic [MONT_W-1:0] res_q;
    logic [7:0]        cnt_q;
    logic              run_q;
    logic              done_q;

    logic [MONT_W+1:0] sum_add_d;
    logic [MONT_W+1:0] sum_red_d;
    logic [MONT_W+1:0] acc_d;
    logic [MONT_W-1:0] fin_d;

    // One iteration: add a_i*B, make the sum even with a multiple of N, halve.
    // The accumulator stays below N+B < 2N+19, so the final result needs up
    // to two subtractions of N to land in [0, N).
    always_comb begin
        sum_add_d = acc_q + (a_q[0] ? {2'b00, b_q} : '0);
        sum_red_d = sum_add_d[0] ? (sum_add_d + N_EXT) : sum_add_d;
        acc_d     = sum_red_d >> 1;
        if (acc_d >= N2_EXT) begin
            fin_d = MONT_W'(acc_d - N2_EXT);
        end else if (acc_d >= N_EXT) begin
            fin_d = MONT_W'(acc_d - N_EXT);
        end else begin
            fin_d = MONT_W'(acc_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                a_q   <= a_i;
                b_q   <= b_i;
                acc_q <= '0;
                cnt_q <= 8'd255;
                run_q <= 1'b1;
            end else if (run_q) begin
                acc_q <= acc_d;
                a_q   <= a_q >> 1;
                cnt_q <= cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                    res_q  <= fin_d;
                end
            end
        end
    end

    assign done_o = done_q;
    assign res_o  = res_q;

endmodule

// File: rtl/mont_sched.sv
// -----------------------------------------------------------------------------
// mont_sched
// Round-robin scheduler sharing one Montgomery multiplier among NREQ
// requesters, with a WAIT-state watchdog.
// Ports:
//   i_clk    : clock (rising edge)
//   i_rst    : asynchronous active-high reset (also the multiplier's
//              synchronous reset, so hold it across a rising edge)
//   i_req    : per-requester request level, held until its o_ack
//   i_a/i_b  : packed operands, slice k belongs to requester k
//   o_gnt    : registered one-hot owner of the multiplier
//   o_ack    : one-cycle one-hot completion pulse
//   o_result : product, valid while any o_ack bit is high
//   o_err    : watchdog timeout flag, coincident with o_ack
//   o_busy   : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mont_sched
    import mont_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int WDOG = WDOG_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*MONT_W-1:0] i_a,
    input  logic [NREQ*MONT_W-1:0] i_b,
    output logic [NREQ-1:0]        o_gnt,
    output logic [NREQ-1:0]        o_ack,
    output logic [MONT_W-1:0]      o_result,
    output logic                   o_err,
    output logic                   o_busy
);

    localparam logic [8:0] WDOG_LAST = 9'(WDOG - 1);

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   ack_q;
    logic [1:0]        gnt_idx_q;
    logic [1:0]        last_q;
    logic [8:0]        wcnt_q;
    logic [MONT_W-1:0] result_q;
    logic              err_q;

    logic [NREQ-1:0]   win_d;
    logic [1:0]        win_idx_d;
    logic              win_found_d;
    int                cand;

    logic [MONT_W-1:0] a_mask [NREQ];
    logic [MONT_W-1:0] b_mask [NREQ];
    logic [MONT_W-1:0] mul_a;
    logic [MONT_W-1:0] mul_b;
    logic              mul_start;
    logic              mul_done;
    logic [MONT_W-1:0] mul_res;

    // Round-robin pick: scan from the requester after the last winner.
    always_comb begin
        win_d       = '0;
        win_idx_d   = '0;
        win_found_d = 1'b0;
        cand        = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(last_q) + off) % NREQ;
            if (!win_found_d && i_req[cand]) begin
                win_found_d = 1'b1;
                win_d[cand] = 1'b1;
                win_idx_d   = 2'(cand);
            end
        end
    end

    // Operands are selected by the registered grant, so requesters only
    // have to keep them stable while the grant is in ISSUE.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_mask[gi] = i_a[gi*MONT_W +: MONT_W] & {MONT_W{gnt_q[gi]}};
            assign b_mask[gi] = i_b[gi*MONT_W +: MONT_W] & {MONT_W{gnt_q[gi]}};
        end
    endgenerate

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            mul_a = mul_a | a_mask[k];
            mul_b = mul_b | b_mask[k];
        end
    end

    assign mul_start = (state_q == ISSUE);

    mont_sched_mont u_mont (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .start_i (mul_start),
        .a_i     (mul_a),
        .b_i     (mul_b),
        .done_o  (mul_done),
        .res_o   (mul_res)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            gnt_idx_q <= '0;
            last_q    <= 2'(NREQ - 1);
            wcnt_q    <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        gnt_q     <= win_d;
                        gnt_idx_q <= win_idx_d;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // done is only looked at here; pulses in other states are dropped.
                    if (mul_done) begin
                        result_q <= mul_res;
                        ack_q    <= gnt_q;
                        wcnt_q   <= '0;
                        state_q  <= RESP;
                    end else if (wcnt_q == WDOG_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        ack_q    <= gnt_q;
                        wcnt_q   <= '0;
                        state_q  <= RESP;
                    end else begin
                        wcnt_q <= wcnt_q + 9'd1;
                    end
                end
                RESP: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    gnt_q   <= '0;
                    last_q  <= gnt_idx_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_gnt    = gnt_q;
    assign o_ack    = ack_q;
    assign o_result = result_q;
    assign o_err    = err_q;
    assign o_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mont_sched.sv
// -----------------------------------------------------------------------------
// tb_mont_sched
// Self-checking bench for mont_sched (NREQ=2, WDOG=300). Expected acks are
// queued when a request is driven and compared when o_ack fires; results
// come from an independent modular-arithmetic model.
// -----------------------------------------------------------------------------
module tb_mont_sched;

    localparam int NREQ = 2;
    localparam int W    = 255;
    localparam int WDOG = 300;
    localparam int LAT  = 257;
    localparam logic [W-1:0] P = {W{1'b1}} - 255'd18;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   a_bus;
    logic [NREQ*W-1:0]   b_bus;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic [W-1:0]        result;
    logic                err;
    logic                busy;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [W-1:0]    res;
        logic            err;
        int              at_edge;
    } exp_t;

    typedef struct {
        int              idx;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [NREQ-1:0] exp_ack;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[7];

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    int acks_seen = 0;
    int txn       = 0;

    mont_sched #(.NREQ(NREQ), .WDOG(WDOG)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (req),
        .i_a      (a_bus),
        .i_b      (b_bus),
        .o_gnt    (gnt),
        .o_ack    (ack),
        .o_result (result),
        .o_err    (err),
        .o_busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: A*B mod P by shift-and-add, then 255 modular halvings.
    function automatic logic [W-1:0] mont_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+1:0] p;
        logic [W+1:0] r;
        logic [W+1:0] bm;
        p  = {2'b00, P};
        r  = '0;
        bm = {2'b00, b};
        if (bm >= p) bm = bm - p;
        for (int i = W - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= p) r = r - p;
            if (a[i]) begin
                r = r + bm;
                if (r >= p) r = r - p;
            end
        end
        for (int i = 0; i < W; i++) begin
            if (r[0]) r = r + p;
            r = r >> 1;
        end
        return r[W-1:0];
    endfunction

    // Ack monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (ack !== '0) begin
            acks_seen = acks_seen + 1;
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_ack got ack=%b at edge %0d, required none", ack, cyc);
            end else begin
                mon_e = sb.pop_front();
                txn = txn + 1;
                $display("txn %0d ack=%b err=%b edge=%0d result=%h", txn, ack, err, cyc, result);
                checks = checks + 1;
                if (ack !== mon_e.ack) begin
                    errors = errors + 1;
                    $display("FAIL ack_vec got %b required %b", ack, mon_e.ack);
                end
                checks = checks + 1;
                if (err !== mon_e.err) begin
                    errors = errors + 1;
                    $display("FAIL ack_err got %b required %b", err, mon_e.err);
                end
                checks = checks + 1;
                if (result !== mon_e.res) begin
                    errors = errors + 1;
                    $display("FAIL ack_result got %h required %h", result, mon_e.res);
                end
                checks = checks + 1;
                if (cyc != mon_e.at_edge) begin
                    errors = errors + 1;
                    $display("FAIL ack_edge got %0d required %0d", cyc, mon_e.at_edge);
                end
            end
        end
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [NREQ-1:0] a, input logic [W-1:0] r,
                            input logic e, input int at);
        exp_t x;
        x.ack = a;
        x.res = r;
        x.err = e;
        x.at_edge = at;
        sb.push_back(x);
    endtask

    task automatic wait_ack(input int budget);
        int target;
        int n;
        target = acks_seen + 1;
        n = 0;
        while (acks_seen < target && n < budget) begin
            nstep();
            n++;
        end
        if (acks_seen < target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL ack_timeout got no ack after %0d cycles, required one", budget);
            sb.delete();
        end
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        a_bus[idx*W +: W] = a;
        b_bus[idx*W +: W] = b;
    endtask

    task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input logic e, input int lat);
        nstep();
        set_ops(idx, a, b);
        req[idx] = 1'b1;
        push_exp(NREQ'(1 << idx), res, e, cyc + 1 + lat);
        nstep();
        chk("grant", {254'd0, gnt}, 256'(1 << idx));
        chk("busy_run", {255'd0, busy}, 256'd1);
        wait_ack(lat + 20);
        req[idx] = 1'b0;
        nstep();
        chk("idle_busy", {255'd0, busy}, 256'd0);
        chk("idle_gnt", {254'd0, gnt}, 256'd0);
    endtask

    initial begin
        logic [255:0] t;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] ca0, cb0, ca1, cb1;
        int c;
        int ridx;

        rst   = 1'b1;
        req   = '0;
        a_bus = '0;
        b_bus = '0;

        vecs[0] = '{0, 255'd1, 255'd1, 2'b01};
        vecs[1] = '{1, {W{1'b1}}, {W{1'b1}}, 2'b10};
        vecs[2] = '{0, P - 255'd1, P - 255'd1, 2'b01};
        vecs[3] = '{1, 255'd0, {W{1'b1}}, 2'b10};
        vecs[4] = '{0, 255'd3, 255'd7, 2'b01};
        vecs[5] = '{1, P, 255'd2, 2'b10};
        vecs[6] = '{0, 255'd1 << 254, 255'd1 << 254, 2'b01};

        // Reset state.
        nstep();
        nstep();
        chk("rst_gnt", {254'd0, gnt}, 256'd0);
        chk("rst_ack", {254'd0, ack}, 256'd0);
        chk("rst_result", {1'b0, result}, 256'd0);
        chk("rst_err", {255'd0, err}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        rst = 1'b0;

        // Single request, A=0 B=5.
        run_one(0, 255'd0, 255'd5, 255'd0, 1'b0, LAT);

        // Table vectors.
        for (int i = 0; i < 7; i++) begin
            nstep();
            set_ops(vecs[i].idx, vecs[i].a, vecs[i].b);
            req[vecs[i].idx] = 1'b1;
            push_exp(vecs[i].exp_ack, mont_ref(vecs[i].a, vecs[i].b), 1'b0, cyc + 1 + LAT);
            wait_ack(LAT + 20);
            req = '0;
            nstep();
            chk("vec_idle", {255'd0, busy}, 256'd0);
        end

        // Contention from reset: both requesters held.
        ca0 = 255'd11; cb0 = 255'd13;
        ca1 = {W{1'b1}}; cb1 = 255'd17;
        nstep();
        rst = 1'b1;
        req = 2'b11;
        set_ops(0, ca0, cb0);
        set_ops(1, ca1, cb1);
        nstep();
        nstep();
        rst = 1'b0;
        c = cyc;
        push_exp(2'b01, mont_ref(ca0, cb0), 1'b0, c + 258);
        push_exp(2'b10, mont_ref(ca1, cb1), 1'b0, c + 517);
        push_exp(2'b01, mont_ref(ca0, cb0), 1'b0, c + 776);
        nstep();
        chk("cont_gnt0", {254'd0, gnt}, 256'd1);
        wait_ack(300);
        nstep();
        nstep();
        chk("cont_gnt1", {254'd0, gnt}, 256'd2);
        wait_ack(300);
        nstep();
        nstep();
        chk("cont_gnt2", {254'd0, gnt}, 256'd1);
        wait_ack(300);
        req = '0;
        nstep();
        nstep();
        chk("cont_idle", {255'd0, busy}, 256'd0);

        // Random operands.
        for (int i = 0; i < 200; i++) begin
            t  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            ra = t[W-1:0];
            t  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            rb = t[W-1:0];
            ridx = int'($urandom_range(0, 1));
            run_one(ridx, ra, rb, mont_ref(ra, rb), 1'b0, LAT);
        end

        // Reset in WAIT cycle 100 discards the operation.
        nstep();
        set_ops(0, 255'd99, 255'd123);
        req[0] = 1'b1;
        repeat (101) nstep();
        chk("midw_busy", {255'd0, busy}, 256'd1);
        rst = 1'b1;
        nstep();
        chk("midw_rst_ack", {254'd0, ack}, 256'd0);
        chk("midw_rst_busy", {255'd0, busy}, 256'd0);
        chk("midw_rst_gnt", {254'd0, gnt}, 256'd0);
        nstep();
        rst = 1'b0;
        c = cyc;
        push_exp(2'b01, mont_ref(255'd99, 255'd123), 1'b0, c + 1 + LAT);
        nstep();
        chk("midw_regrant", {254'd0, gnt}, 256'd1);
        wait_ack(300);
        req = '0;
        nstep();
        chk("midw_idle", {255'd0, busy}, 256'd0);

        // Watchdog: multiplier done held low.
        force dut.mul_done = 1'b0;
        run_one(0, 255'd5, 255'd6, 255'd0, 1'b1, WDOG + 1);
        release dut.mul_done;

        // Requester 1 drops its request during WAIT.
        nstep();
        set_ops(1, 255'd1234, 255'd5678);
        req[1] = 1'b1;
        c = cyc;
        push_exp(2'b10, mont_ref(255'd1234, 255'd5678), 1'b0, c + 1 + LAT);
        repeat (50) nstep();
        req[1] = 1'b0;
        wait_ack(300);
        repeat (3) nstep();
        chk("drop_gnt", {254'd0, gnt}, 256'd0);
        chk("drop_busy", {255'd0, busy}, 256'd0);

        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_drain got %0d pending, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout got no finish, required finish");
        $fatal(1, "simulation time limit");
    end

endmodule
